// File: rtl/hp_bar_renderer.sv
// hp_bar_renderer: HUD health-bar pixel front end.
// Tracks player HP, runs a blink on the mask that was just lost, and for each
// DrawX/DrawY produces a registered sprite-ROM address, in-sprite flag and
// full/empty image select. Pixel outputs follow the input pixel by one cycle.
module hp_bar_renderer #(
    parameter int MAX_HP       = 5,
    parameter int SPR_W        = 12,
    parameter int SPR_H        = 16,
    parameter int X0           = 16,
    parameter int Y0           = 16,
    parameter int GAP          = 4,
    parameter int FLASH_FRAMES = 16
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       frame_start,
    input  logic       damage,
    input  logic       heal,
    output logic [7:0] rom_address,
    output logic       sprite_on,
    output logic       mask_full,
    output logic [2:0] hp,
    output logic       dead
);

    localparam int              CW       = $clog2(FLASH_FRAMES) + 1;
    localparam logic [2:0]      HP_MAX   = 3'(MAX_HP);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(FLASH_FRAMES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [9:0]      Y_TOP    = 10'(Y0);
    localparam logic [9:0]      Y_BOT    = 10'(Y0 + SPR_H - 1);
    localparam logic [7:0]      W8       = 8'(SPR_W);

    typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      hp_q, hp_d;
    logic            dead_q, dead_d;
    logic [CW-1:0]   flash_cnt_q, flash_cnt_d;
    logic [2:0]      flash_slot_q, flash_slot_d;
    logic [7:0]      rom_address_q, rom_address_d;
    logic            sprite_on_q, sprite_on_d;
    logic            mask_full_q, mask_full_d;

    logic            dmg_eff_s;
    logic            heal_eff_s;
    logic            y_in_s;
    logic [3:0]      ly_s;
    logic [3:0]      lx_sel_s;
    logic [MAX_HP-1:0] hit_s;
    logic [MAX_HP-1:0] full_s;
    logic [3:0]      lx_s [MAX_HP];

    // A pulse only counts when it actually moves HP; simultaneous pulses cancel.
    assign dmg_eff_s  = damage && !heal && (hp_q != 3'd0);
    assign heal_eff_s = heal && !damage && (hp_q != HP_MAX);

    assign y_in_s = (DrawY >= Y_TOP) && (DrawY <= Y_BOT);
    assign ly_s   = 4'(DrawY - Y_TOP);

    // One comparator pair per slot; slots never overlap so at most one hits.
    for (genvar g = 0; g < MAX_HP; g++) begin : g_slot
        localparam logic [9:0] SX  = 10'(X0 + g * (SPR_W + GAP));
        localparam logic [9:0] SXE = 10'(X0 + g * (SPR_W + GAP) + SPR_W - 1);
        assign hit_s[g]  = y_in_s && (DrawX >= SX) && (DrawX <= SXE);
        assign lx_s[g]   = 4'(DrawX - SX);
        assign full_s[g] = ((state_q == FLASH) && (flash_slot_q == 3'(g)))
                           ? flash_cnt_q[2] : (3'(g) < hp_q);
    end

    // Pick the local column of whichever slot is hit and form the pixel outputs.
    always_comb begin
        lx_sel_s = 4'd0;
        for (int i = 0; i < MAX_HP; i++) begin
            if (hit_s[i]) begin
                lx_sel_s = lx_sel_s | lx_s[i];
            end else begin
                lx_sel_s = lx_sel_s;
            end
        end
        sprite_on_d = |hit_s;
        mask_full_d = |(hit_s & full_s);
        if (sprite_on_d) begin
            rom_address_d = 8'(ly_s * W8) + {4'd0, lx_sel_s};
        end else begin
            rom_address_d = 8'd0;
        end
    end

    // HP arithmetic and flash FSM next state.
    always_comb begin
        hp_d         = hp_q;
        state_d      = state_q;
        flash_cnt_d  = flash_cnt_q;
        flash_slot_d = flash_slot_q;
        if (dmg_eff_s) begin
            hp_d = hp_q - 3'd1;
        end else if (heal_eff_s) begin
            hp_d = hp_q + 3'd1;
        end else begin
            hp_d = hp_q;
        end
        case (state_q)
            IDLE: begin
                if (dmg_eff_s) begin
                    state_d      = FLASH;
                    flash_cnt_d  = CNT_LOAD;
                    flash_slot_d = hp_q - 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            FLASH: begin
                // Damage beats frame_start: reload rather than decrement.
                if (dmg_eff_s) begin
                    flash_cnt_d  = CNT_LOAD;
                    flash_slot_d = hp_q - 3'd1;
                end else if (heal_eff_s) begin
                    state_d     = IDLE;
                    flash_cnt_d = '0;
                end else if (frame_start) begin
                    flash_cnt_d = flash_cnt_q - CNT_ONE;
                    if (flash_cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLASH;
                    end
                end else begin
                    state_d = FLASH;
                end
            end
            default: begin
                state_d     = IDLE;
                flash_cnt_d = '0;
            end
        endcase
        dead_d = (hp_d == 3'd0);
    end

    // State and pixel output registers; reset aborts any blink and restores full HP.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hp_q          <= HP_MAX;
            dead_q        <= 1'b0;
            flash_cnt_q   <= '0;
            flash_slot_q  <= 3'd0;
            rom_address_q <= 8'd0;
            sprite_on_q   <= 1'b0;
            mask_full_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hp_q          <= hp_d;
            dead_q        <= dead_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_slot_q  <= flash_slot_d;
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
            mask_full_q   <= mask_full_d;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_on   = sprite_on_q;
    assign mask_full   = mask_full_q;
    assign hp          = hp_q;
    assign dead        = dead_q;

endmodule

// File: tb/tb_hp_bar_renderer.sv
// Self-checking bench for hp_bar_renderer: geometry table, directed blink /
// heal / death / reset sequences, and randomized traffic against a model.
module tb_hp_bar_renderer;

    localparam int MAXHP = 5;
    localparam int SW    = 12;
    localparam int SH    = 16;
    localparam int SX0   = 16;
    localparam int SY0   = 16;
    localparam int SGAP  = 4;
    localparam int FF    = 16;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
    logic       damage;
    logic       heal;
    logic [7:0] rom_address;
    logic       sprite_on;
    logic       mask_full;
    logic [2:0] hp;
    logic       dead;

    hp_bar_renderer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .damage      (damage),
        .heal        (heal),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .mask_full   (mask_full),
        .hp          (hp),
        .dead        (dead)
    );

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int m_hp;
    bit m_flash;
    int m_cnt;
    int m_slot;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] addr;
        logic       on;
        logic       full;
    } vec_t;

    vec_t tbl [10];
    bit   fexp [16];

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got addr=%0d on=%0b full=%0b hp=%0d dead=%0b, want addr=%0d on=%0b full=%0b hp=%0d dead=%0b",
                     name, act[13:6], act[5], act[4], act[3:1], act[0],
                     exp[13:6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {rom_address, sprite_on, mask_full, hp, dead};
    endfunction

    task automatic model_reset();
        m_hp = MAXHP; m_flash = 1'b0; m_cnt = 0; m_slot = 0;
    endtask

    // What the bar looks like at pixel (x,y) given the current model state.
    task automatic model_pixel(input int x, input int y,
                               output logic [7:0] addr, output logic on, output logic full);
        addr = 8'd0; on = 1'b0; full = 1'b0;
        for (int i = 0; i < MAXHP; i++) begin
            int sx;
            sx = SX0 + i * (SW + SGAP);
            if (x >= sx && x < sx + SW && y >= SY0 && y < SY0 + SH) begin
                on   = 1'b1;
                addr = 8'((y - SY0) * SW + (x - sx));
                full = (i < m_hp);
                if (m_flash && i == m_slot) full = (((m_cnt / 4) % 2) == 1);
            end
        end
    endtask

    task automatic model_tick(input bit d, input bit h, input bit f);
        bit ed, eh;
        ed = d && !h && (m_hp > 0);
        eh = h && !d && (m_hp < MAXHP);
        if (ed) begin
            m_hp   = m_hp - 1;
            m_flash = 1'b1;
            m_cnt  = FF;
            m_slot = m_hp;
        end else begin
            if (eh) m_hp = m_hp + 1;
            if (m_flash) begin
                if (eh) begin
                    m_flash = 1'b0;
                    m_cnt   = 0;
                end else if (f) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_flash = 1'b0;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input int x, input int y, input bit d, input bit h, input bit f);
        logic [7:0] ea;
        logic       eo, ef;
        DrawX = 10'(x); DrawY = 10'(y);
        damage = d; heal = h; frame_start = f;
        @(posedge vga_clk);
        model_pixel(x, y, ea, eo, ef);
        model_tick(d, h, f);
        #1;
        check("model", dut_vec(), {ea, eo, ef, 3'(m_hp), (m_hp == 0)});
        damage = 1'b0; heal = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{10'd16, 10'd16, 8'd0,   1'b1, 1'b1};
        tbl[1] = '{10'd27, 10'd31, 8'd191, 1'b1, 1'b1};
        tbl[2] = '{10'd28, 10'd20, 8'd0,   1'b0, 1'b0};
        tbl[3] = '{10'd31, 10'd20, 8'd0,   1'b0, 1'b0};
        tbl[4] = '{10'd32, 10'd20, 8'd48,  1'b1, 1'b1};
        tbl[5] = '{10'd15, 10'd16, 8'd0,   1'b0, 1'b0};
        tbl[6] = '{10'd91, 10'd16, 8'd11,  1'b1, 1'b1};
        tbl[7] = '{10'd92, 10'd16, 8'd0,   1'b0, 1'b0};
        tbl[8] = '{10'd16, 10'd32, 8'd0,   1'b0, 1'b0};
        tbl[9] = '{10'd16, 10'd15, 8'd0,   1'b0, 1'b0};
        fexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        frame_start = 1'b0; damage = 1'b0; heal = 1'b0;
        model_reset();
        #12;
        check("reset_state", dut_vec(), {8'd0, 1'b0, 1'b0, 3'd5, 1'b0});
        @(negedge vga_clk);
        reset_n = 1'b1;

        // geometry table at full HP
        for (int i = 0; i < 10; i++) begin
            step(int'(tbl[i].x), int'(tbl[i].y), 1'b0, 1'b0, 1'b0);
            check("geom", dut_vec(), {tbl[i].addr, tbl[i].on, tbl[i].full, 3'd5, 1'b0});
        end

        // blink of slot 4 over 16 frames
        step(80, 16, 1'b1, 1'b0, 1'b0);
        step(80, 16, 1'b0, 1'b0, 1'b0);
        check("flash_cnt16", {6'd0, mask_full, hp, 4'd0}, {6'd0, 1'b0, 3'd4, 4'd0});
        for (int k = 0; k < 16; k++) begin
            step(80, 16, 1'b0, 1'b0, 1'b1);
            step(80, 16, 1'b0, 1'b0, 1'b0);
            check("flash_seq", {8'd0, 1'b0, mask_full, 4'd0}, {8'd0, 1'b0, fexp[k], 4'd0});
        end
        step(80, 16, 1'b0, 1'b1, 1'b0);

        // heal aborts a blink
        step(80, 16, 1'b1, 1'b0, 1'b0);
        step(80, 16, 1'b0, 1'b0, 1'b1);
        step(80, 16, 1'b0, 1'b0, 1'b1);
        step(80, 16, 1'b0, 1'b1, 1'b0);
        step(80, 16, 1'b0, 1'b0, 1'b0);
        check("heal_abort", dut_vec(), {8'd0, 1'b1, 1'b1, 3'd5, 1'b0});
        for (int k = 0; k < 5; k++) step(80, 16, 1'b0, 1'b0, 1'b1);
        check("heal_steady", {8'd0, 1'b0, mask_full, 4'd0}, {8'd0, 1'b0, 1'b1, 4'd0});

        // down to zero and beyond
        for (int k = 0; k < 5; k++) step(16, 16, 1'b1, 1'b0, 1'b0);
        check("dead", {10'd0, hp, dead}, {10'd0, 3'd0, 1'b1});
        step(16, 16, 1'b1, 1'b0, 1'b0);
        check("dmg_at_zero", {10'd0, hp, dead}, {10'd0, 3'd0, 1'b1});
        step(16, 16, 1'b1, 1'b1, 1'b0);
        check("dmg_heal_same", {10'd0, hp, dead}, {10'd0, 3'd0, 1'b1});
        step(16, 16, 1'b0, 1'b1, 1'b0);
        check("heal_from_zero", {10'd0, hp, dead}, {10'd0, 3'd1, 1'b0});
        for (int k = 0; k < 5; k++) step(16, 16, 1'b0, 1'b1, 1'b0);
        check("heal_cap", {10'd0, hp, dead}, {10'd0, 3'd5, 1'b0});

        // reset in the middle of a blink (counter at 9)
        step(80, 16, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(80, 16, 1'b0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), {8'd0, 1'b0, 1'b0, 3'd5, 1'b0});
        model_reset();
        @(negedge vga_clk);
        reset_n = 1'b1;
        step(80, 16, 1'b0, 1'b0, 1'b0);
        check("post_reset", dut_vec(), {8'd0, 1'b1, 1'b1, 3'd5, 1'b0});

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(int'($urandom_range(0, 110)), int'($urandom_range(10, 36)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hp_bar_renderer.md
Name: hp_bar_renderer

Overview:
- Per-pixel front end for the HUD health bar; sits directly upstream of the 12x16 HP mask sprite ROM and palette.
- Holds the player HP count, applies damage and heal pulses, and animates a blink on the mask that was just lost.
- For every DrawX/DrawY it produces a registered ROM address, an in-sprite flag and a full/empty select. The downstream ROM clocks on the negedge of vga_clk, so it consumes this address half a cycle later.

Parameters:
- MAX_HP, 5, number of mask slots and the HP ceiling (1..7).
- SPR_W, 12, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- X0, 16, screen X of slot 0's left column.
- Y0, 16, screen Y of the bar's top row.
- GAP, 4, blank pixels between adjacent slots.
- FLASH_FRAMES, 16, length of the loss blink in frames (power of two, at least 8).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- frame_start  in  1  one-cycle pulse once per frame, during vertical blank.
- damage  in  1  one-cycle pulse: lose 1 HP.
- heal  in  1  one-cycle pulse: gain 1 HP.
- rom_address  out  8  sprite ROM address: ly*SPR_W + lx.
- sprite_on  out  1  current pixel lies inside a mask slot.
- mask_full  out  1  1 = select the full-mask image, 0 = the empty-mask image.
- hp  out  3  current HP.
- dead  out  1  high while hp == 0.

Behaviour:
- Reset (asynchronous, reset_n low):
  - hp = MAX_HP, state = IDLE, flash_cnt = 0, flash_slot = 0.
  - rom_address = 0, sprite_on = 0, mask_full = 0, dead = 0.
- HP update, applied on the cycle the pulse is seen:
  - damage alone and hp > 0: hp -= 1.
  - heal alone and hp < MAX_HP: hp += 1.
  - damage and heal in the same cycle: no change.
  - damage at hp = 0: no change. heal at hp = MAX_HP: no change.
  - dead = (hp == 0), registered, updates in the same cycle as hp.
- Flash FSM, two states:
  - IDLE -> FLASH on an effective damage. Set flash_slot = new hp and flash_cnt = FLASH_FRAMES.
  - FLASH, effective damage again: restart the blink on the new slot and reload flash_cnt.
  - FLASH, frame_start: flash_cnt -= 1. When it reaches 0, go to IDLE.
  - FLASH, effective heal: go to IDLE immediately and clear flash_cnt to 0.
  - If frame_start and damage coincide, damage takes priority and the counter is reloaded, not decremented.
- Slot geometry: slot i (0..MAX_HP-1) occupies:
  - x in [X0 + i*(SPR_W+GAP), X0 + i*(SPR_W+GAP) + SPR_W - 1]
  - y in [Y0, Y0 + SPR_H - 1]
  - Hit detection uses one parallel comparator per slot; no dividers.
  - lx = DrawX - slot_x and ly = DrawY - Y0, each narrowed to 4 bits before the address multiply-add.
  - Slots never overlap. Gap pixels, and pixels outside all slots, give sprite_on = 0 and rom_address = 0.
- Full/empty select for a pixel in slot i:
  - base value: mask_full = (i < hp).
  - Override in FLASH when i == flash_slot: mask_full = flash_cnt[2], so the mask toggles every 4 frames.
- Timing:
  - rom_address, sprite_on and mask_full are registered on posedge vga_clk. They correspond to the DrawX/DrawY sampled at that edge: one cycle of latency.
  - A damage pulse changes the pixel outputs from the next cycle onward. A mid-frame change is allowed; no tearing protection is provided.
- Reset asserted mid-blink aborts the blink immediately and restores full HP.

Test Plan:
- Reset release, then DrawX=16, DrawY=16 -> next cycle rom_address=0, sprite_on=1, mask_full=1, hp=5. DrawX=27, DrawY=31 -> rom_address=191.
- DrawX=28..31 (gap), DrawY=20 -> sprite_on=0, rom_address=0. DrawX=32, DrawY=20 -> rom_address=48, sprite_on=1 (slot 1).
- One damage pulse -> hp=4, FLASH with flash_slot=4. Over 16 frame_start pulses, slot 4 (DrawX=80) mask_full follows flash_cnt[2]: 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0 for cnt 16..1 (cnt 16 gives 0). After the 16th pulse: IDLE, mask_full=0.
- Five damage pulses -> hp=0, dead=1. A sixth damage -> hp stays 0. damage+heal in the same cycle -> hp unchanged.
- During FLASH, a heal pulse -> hp back to 5, immediate IDLE, slot 4 mask_full=1 steadily.
- reset_n low mid-FLASH (flash_cnt=9) -> outputs go to reset values asynchronously. After release, hp=5 and state=IDLE.
